// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the receiver.
package ps2_pkg;

  // Host-to-device transmitter states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_RTS     = 3'd2,
    S_SEND    = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5
  } tx_state_e;

  // Host-driven bits after the start bit: 8 data, parity, stop.
  localparam int unsigned TX_FRAME_BITS = 10;
  localparam int unsigned TX_IDX_W      = 4;

  // Device-to-host frame: start, 8 data, parity, stop.
  localparam int unsigned RX_FRAME_BITS = 11;
  localparam int unsigned RX_IDX_W      = 4;

  // Depth of the pad-input synchronisers.
  localparam int unsigned SYNC_STAGES   = 2;

  // PS/2 uses odd parity over the data byte.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the PS/2 clock and data pads and flags falling clock edges.
module ps2_sync_edge
  import ps2_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   fall_q;

  // Synchroniser chains idle high (released bus); edge pulse is prev=1, cur=0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      fall_q      <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_s_o  = clk_sync_q[SYNC_STAGES-1];
  assign data_s_o = data_sync_q[SYNC_STAGES-1];
  assign fall_o   = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, frame, ACK).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_start,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE      = CNT_W'(1);
  localparam logic [TX_IDX_W-1:0] IDX_LAST     = TX_IDX_W'(TX_FRAME_BITS - 1);
  localparam logic [TX_IDX_W-1:0] IDX_ONE      = TX_IDX_W'(1);

  tx_state_e                state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [TX_IDX_W-1:0]      idx_q, idx_d;
  logic [TX_FRAME_BITS-1:0] frame_q, frame_d;
  logic                     ack_err_q, ack_err_d;
  logic                     clk_oe_q, clk_oe_d;
  logic                     data_oe_q, data_oe_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;

  logic                     clk_s;
  logic                     data_s;
  logic                     fall;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     timeout;

  // Pad synchronisation and falling-edge detection.
  ps2_sync_edge u_sync (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .ps2_clk_i  (i_ps2_clk),
    .ps2_data_i (i_ps2_data),
    .clk_s_o    (clk_s),
    .data_s_o   (data_s),
    .fall_o     (fall)
  );

  assign cnt_inc = cnt_q + CNT_ONE;
  assign timeout = (cnt_q == TIMEOUT_LAST);

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      ack_err_q <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      ack_err_q <= ack_err_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    ack_err_d = ack_err_q;
    clk_oe_d  = 1'b0;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        // A start coinciding with the done pulse belongs to the old transfer.
        if (i_start && !done_q) begin
          frame_d   = {1'b1, odd_parity(i_data), i_data};
          cnt_d     = '0;
          idx_d     = '0;
          ack_err_d = 1'b0;
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES == 1);
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_RTS;
        end else begin
          clk_oe_d  = 1'b1;
          data_oe_d = (cnt_inc == INHIBIT_LAST);
          cnt_d     = cnt_inc;
        end
      end

      S_RTS: begin
        data_oe_d = 1'b1;
        idx_d     = '0;
        cnt_d     = cnt_inc;
        state_d   = S_SEND;
      end

      S_SEND: begin
        if (fall) begin
          // Low for a 0, released for a 1; the stop bit is released.
          data_oe_d = ~frame_q[idx_q];
          cnt_d     = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_ACK;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else if (timeout) begin
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          error_d   = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_ACK: begin
        data_oe_d = 1'b0;
        if (fall) begin
          ack_err_d = data_s;
          cnt_d     = '0;
          state_d   = S_RELEASE;
        end else if (timeout) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RELEASE: begin
        data_oe_d = 1'b0;
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          error_d = ack_err_q;
          state_d = S_IDLE;
        end else if (fall) begin
          cnt_d = '0;
        end else if (timeout) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign o_ps2_clk_oe  = clk_oe_q;
  assign o_ps2_data_oe = data_oe_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int unsigned INHIBIT = 8;
  localparam int unsigned TIMEOUT = 200;
  localparam int          HALF    = 10;   // device clock = 1/20 of i_clk

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  logic       clk_oe, data_oe, busy, done, err;
  logic       ps2_clk_line, ps2_data_line;

  int         n_checks = 0;
  int         n_pass   = 0;

  // Wired-AND bus: either side may pull low.
  assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
  assign ps2_data_line = ~(data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_data        (data),
    .i_start       (start),
    .i_ps2_clk     (ps2_clk_line),
    .i_ps2_data    (ps2_data_line),
    .o_ps2_clk_oe  (clk_oe),
    .o_ps2_data_oe (data_oe),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [7:0] b);
    data  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count cycles with clock inhibited; note data_oe on the first and last of them.
  task automatic measure_inhibit(input string name);
    int   n;
    logic first_doe, last_doe;
    n = 0;
    first_doe = data_oe;
    last_doe  = 1'b0;
    while (clk_oe && n < 100) begin
      if (n == int'(INHIBIT) - 1) last_doe = data_oe;
      n++;
      tick();
    end
    check_eq($sformatf("%s_inhibit_len", name), n, INHIBIT);
    check_eq($sformatf("%s_inhibit_first_doe", name), first_doe, 1'b0);
    check_eq($sformatf("%s_inhibit_last_doe", name), last_doe, 1'b1);
  endtask

  // Device side: wait for RTS, clock n_edges bits (sampled on rising edge), then ACK.
  task automatic run_frame(input string name, input int n_edges, input bit do_ack,
                           input bit poke, output logic start_bit, output logic [9:0] bits);
    int w;
    w    = 0;
    bits = '0;
    while (!(ps2_clk_line && !ps2_data_line) && w < 50) begin
      w++;
      tick();
    end
    check_eq($sformatf("%s_rts_seen", name), (w < 50), 1'b1);
    start_bit = ps2_data_line;
    repeat (4) tick();
    for (int k = 0; k < n_edges; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) tick();
      dev_clk_low = 1'b0;
      bits[k] = ps2_data_line;
      if (poke && k == 2) begin
        data  = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq($sformatf("%s_busy_at_poke", name), busy, 1'b1);
        repeat (HALF - 1) tick();
      end else begin
        repeat (HALF) tick();
      end
    end
    if (n_edges == 10) begin
      dev_data_low = do_ack;
      repeat (3) tick();
      dev_clk_low = 1'b1;
      repeat (HALF) tick();
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
    end
  endtask

  // Full transfer with hand-computed expected byte, parity and error.
  task automatic do_tx(input string name, input logic [7:0] b, input logic par,
                       input bit do_ack, input bit poke, input logic exp_err);
    logic       sb;
    logic [9:0] bits;
    int         cyc;
    start_tx(b);
    check_eq($sformatf("%s_busy", name), busy, 1'b1);
    measure_inhibit(name);
    run_frame(name, 10, do_ack, poke, sb, bits);
    check_eq($sformatf("%s_start_bit", name), sb, 1'b0);
    check_eq($sformatf("%s_data", name), bits[7:0], b);
    check_eq($sformatf("%s_parity", name), bits[8], par);
    check_eq($sformatf("%s_stop", name), bits[9], 1'b1);
    cyc = 0;
    while (!done && cyc < 400) begin
      cyc++;
      tick();
    end
    check_eq($sformatf("%s_done", name), done, 1'b1);
    check_eq($sformatf("%s_error", name), err, exp_err);
    // Start raised during the done cycle must not launch a transfer.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq($sformatf("%s_done_pulse", name), done, 1'b0);
    check_eq($sformatf("%s_start_on_done_ignored", name), busy, 1'b0);
    repeat (3) tick();
  endtask

  initial begin : main
    logic       sb;
    logic [9:0] bits;
    int         cyc;
    logic       seen_done;

    repeat (3) tick();
    check_eq("reset_outputs", {clk_oe, data_oe, busy, done, err}, 5'b0);
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("idle_lines_released", {clk_oe, data_oe}, 2'b00);

    // 0xED has six ones -> parity 1.
    do_tx("ed", 8'hED, 1'b1, 1'b1, 1'b0, 1'b0);
    do_tx("x01", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    do_tx("x00", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    // Device withholds ACK.
    do_tx("nack", 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    // Start pulse with 0xFF mid-frame is ignored; 0x3C has four ones.
    do_tx("busy_ign", 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);

    // Device stops after 4 falling edges: 3 cycles of sync/edge latency,
    // one to clear the counter, then TIMEOUT cycles to reach the abort.
    start_tx(8'hA5);
    measure_inhibit("tmo");
    run_frame("tmo", 3, 1'b0, 1'b0, sb, bits);
    check_eq("tmo_partial_bits", bits[2:0], 3'b101);
    dev_clk_low = 1'b1;
    cyc = 0;
    while (!done && cyc < 400) begin
      cyc++;
      if (cyc == HALF + 1) dev_clk_low = 1'b0;
      tick();
    end
    check_eq("tmo_latency", cyc, TIMEOUT + 4);
    check_eq("tmo_error", {done, err}, 2'b11);
    check_eq("tmo_lines_released", {clk_oe, data_oe}, 2'b00);
    tick();
    check_eq("tmo_idle", {done, busy}, 2'b00);
    repeat (3) tick();

    // Reset mid-SEND while data is driven low (0x12 bit 2 = 0).
    start_tx(8'h12);
    measure_inhibit("rst");
    run_frame("rst", 3, 1'b0, 1'b0, sb, bits);
    check_eq("rst_pre_data_oe", data_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_lines_released", {clk_oe, data_oe}, 2'b00);
    seen_done = 1'b0;
    repeat (3) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    check_eq("rst_no_done", seen_done, 1'b0);
    check_eq("rst_idle", busy, 1'b0);
    // 0xF4 has five ones -> parity 0.
    do_tx("f4", 8'hF4, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
